ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter. It sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the host to the keyboard over the shared open-drain ps2_clk/ps2_data lines. It is the outbound counterpart of the keyboard receive path and shares the same pins through open-drain enables. The receiver must ignore the bus while busy is high.

---
 rtl/ps2_host_tx.sv | 220 ++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_host_tx
//  Purpose  : PS/2 host-to-device byte transmitter over open-drain clk/data.
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
    parameter int unsigned CLK_HZ         = 25000000,
    parameter int unsigned INHIBIT_CYCLES = 3000,
    parameter int unsigned TIMEOUT_CYCLES = 375000,
    parameter int unsigned FILTER_CYCLES  = 8
) (
    input  logic       clk25,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                        : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned FLT_W   = $clog2(FILTER_CYCLES + 1);

    localparam logic [CNT_W-1:0] C_INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_INH_DATA = CNT_W'(INHIBIT_CYCLES - 2);
    localparam logic [CNT_W-1:0] C_TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FLT_W-1:0] C_FLT_LAST = FLT_W'(FILTER_CYCLES - 1);
    localparam logic [3:0]       C_IDX_STOP = 4'd9;

    generate
        if (CLK_HZ == 0 || INHIBIT_CYCLES < 2 || TIMEOUT_CYCLES < 2 || FILTER_CYCLES < 1) begin : g_param_check
            $error("ps2_host_tx: illegal parameter value");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_RTS       = 3'd2,
        ST_SEND      = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } state_t;

    // Line index 0 is ps2_clk, index 1 is ps2_data.
    logic [1:0]            r_sync1;
    logic [1:0]            r_sync2;
    logic [1:0]            r_filt;
    logic [1:0][FLT_W-1:0] r_flt_cnt;
    logic                  r_clk_prev;
    logic                  w_fall;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [8:0]       r_shift, w_shift_nxt;
    logic [3:0]       r_idx, w_idx_nxt;
    logic             r_clk_oe, w_clk_oe_nxt;
    logic             r_data_oe, w_data_oe_nxt;
    logic             r_ack_ok, w_ack_ok_nxt;
    logic             r_done, w_done_nxt;
    logic             r_error, w_error_nxt;
    logic             w_in_frame;

    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1    <= 2'b11;
            r_sync2    <= 2'b11;
            r_filt     <= 2'b11;
            r_flt_cnt  <= '0;
            r_clk_prev <= 1'b1;
        end else begin
            r_sync1    <= {ps2_data_in, ps2_clk_in};
            r_sync2    <= r_sync1;
            r_clk_prev <= r_filt[0];
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_flt_cnt[i] <= '0;
                end else if (r_flt_cnt[i] == C_FLT_LAST) begin
                    r_filt[i]    <= r_sync2[i];
                    r_flt_cnt[i] <= '0;
                end else begin
                    r_flt_cnt[i] <= r_flt_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_fall     = r_clk_prev & ~r_filt[0];
    assign w_in_frame = (r_state == ST_SEND) || (r_state == ST_ACK) || (r_state == ST_WAIT_IDLE);

    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_idx     <= '0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_ack_ok  <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_idx     <= w_idx_nxt;
            r_clk_oe  <= w_clk_oe_nxt;
            r_data_oe <= w_data_oe_nxt;
            r_ack_ok  <= w_ack_ok_nxt;
            r_done    <= w_done_nxt;
            r_error   <= w_error_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_shift_nxt   = r_shift;
        w_idx_nxt     = r_idx;
        w_clk_oe_nxt  = r_clk_oe;
        w_data_oe_nxt = r_data_oe;
        w_ack_ok_nxt  = r_ack_ok;
        w_done_nxt    = 1'b0;
        w_error_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_clk_oe_nxt  = 1'b0;
                w_data_oe_nxt = 1'b0;
                if (tx_valid) begin
                    w_shift_nxt  = {~^tx_data, tx_data};
                    w_cnt_nxt    = '0;
                    w_clk_oe_nxt = 1'b1;
                    w_state_nxt  = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == C_INH_DATA) begin
                    w_data_oe_nxt = 1'b1;
                end
                if (r_cnt == C_INH_LAST) begin
                    w_clk_oe_nxt = 1'b0;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = ST_RTS;
                end
            end
            ST_RTS: begin
                w_data_oe_nxt = 1'b1;
                w_cnt_nxt     = '0;
                w_idx_nxt     = '0;
                w_state_nxt   = ST_SEND;
            end
            ST_SEND: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (w_fall) begin
                    w_cnt_nxt = '0;
                    if (r_idx == C_IDX_STOP) begin
                        w_data_oe_nxt = 1'b0;
                        w_state_nxt   = ST_ACK;
                    end else begin
                        w_data_oe_nxt = ~r_shift[0];
                        w_shift_nxt   = {1'b0, r_shift[8:1]};
                        w_idx_nxt     = r_idx + 4'd1;
                    end
                end
            end
            ST_ACK: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (w_fall) begin
                    w_cnt_nxt    = '0;
                    w_ack_ok_nxt = ~r_filt[1];
                    w_state_nxt  = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_filt == 2'b11) begin
                    w_done_nxt  = r_ack_ok;
                    w_error_nxt = ~r_ack_ok;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else if (w_fall) begin
                    w_cnt_nxt = '0;
                end
            end
            default: begin
                w_clk_oe_nxt  = 1'b0;
                w_data_oe_nxt = 1'b0;
                w_state_nxt   = ST_IDLE;
            end
        endcase

        // A silent device: abandon the frame and free both lines.
        if (w_in_frame && (w_state_nxt == r_state) && !w_fall && (r_cnt == C_TO_LAST)) begin
            w_clk_oe_nxt  = 1'b0;
            w_data_oe_nxt = 1'b0;
            w_error_nxt   = 1'b1;
            w_cnt_nxt     = '0;
            w_state_nxt   = ST_IDLE;
        end
    end

    assign tx_ready    = (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign tx_done     = r_done;
    assign tx_error    = r_error;
    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_host_tx
//  Purpose  : Scoreboard bench for ps2_host_tx with a behavioural PS/2 device.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

    localparam int INH  = 3000;
    localparam int TO   = 2000;
    localparam int FLT  = 8;
    localparam int HALF = 50;

    typedef enum int {M_ACK, M_NACK, M_SILENT, M_GLITCH, M_ABORT} mode_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, tx_done, tx_error;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       ps2_clk_in, ps2_data_in;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .CLK_HZ         (25000000),
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO),
        .FILTER_CYCLES  (FLT)
    ) dut (
        .clk25       (clk),
        .reset_n     (reset_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .tx_done     (tx_done),
        .tx_error    (tx_error),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #20 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          exp_q[$];
    logic [10:0] frame_q[$];
    mode_t       dev_mode = M_ACK;
    bit          dev_busy = 1'b0;
    bit          bit4_seen = 1'b0;
    longint      rel_cyc = 0;
    longint      err_cyc = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Device view of a frame: start, 8 data bits LSB first, odd parity, stop.
    function automatic logic [10:0] ref_frame(input logic [7:0] b);
        int   ones = 0;
        logic par;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        par = (ones % 2 == 0);
        return {1'b1, par, b, 1'b0};
    endfunction

    // Scoreboard monitor: outcome pulses and inhibit length.
    initial begin
        int hi_cnt = 0;
        forever begin
            @(negedge clk);
            if (tx_done || tx_error) begin
                if (tx_done && tx_error) check("done_and_error_together", 1, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", tx_done ? 1 : 2, 0);
                end else begin
                    check("outcome_done", longint'(tx_done), longint'(exp_q.pop_front()));
                end
                if (tx_error) err_cyc = cyc;
            end
            if (ps2_clk_oe) begin
                hi_cnt++;
            end else if (hi_cnt != 0) begin
                check("inhibit_len", hi_cnt, INH);
                hi_cnt  = 0;
                rel_cyc = cyc;
            end
        end
    end

    // Behavioural device: clocks 11 pulses, samples data on its rising edges.
    initial begin
        logic [10:0] got;
        logic [10:0] expf;
        bit          aborted;
        forever begin
            wait (ps2_clk_oe == 1'b1);
            wait (ps2_clk_oe == 1'b0);
            if (dev_mode != M_SILENT) begin
                dev_busy = 1'b1;
                aborted  = 1'b0;
                got      = '0;
                repeat (20) @(negedge clk);
                got[0] = ps2_data_in;
                for (int k = 1; k <= 11; k++) begin
                    repeat (HALF) @(negedge clk);
                    dev_clk_low = 1'b1;
                    if (dev_mode == M_ABORT && k == 5) begin
                        bit4_seen = 1'b1;
                        repeat (HALF) @(negedge clk);
                        dev_clk_low = 1'b0;
                        aborted = 1'b1;
                        break;
                    end
                    repeat (HALF) @(negedge clk);
                    dev_clk_low = 1'b0;
                    if (k <= 10) got[k] = ps2_data_in;
                    if (k == 4 && dev_mode == M_GLITCH) begin
                        repeat (20) @(negedge clk);
                        dev_clk_low = 1'b1;
                        repeat (3) @(negedge clk);
                        dev_clk_low = 1'b0;
                    end
                    if (k == 10 && dev_mode != M_NACK) begin
                        repeat (10) @(negedge clk);
                        dev_data_low = 1'b1;
                    end
                end
                if (!aborted) begin
                    repeat (20) @(negedge clk);
                    dev_data_low = 1'b0;
                    if (frame_q.size() == 0) begin
                        check("frame_unexpected", 1, 0);
                    end else begin
                        expf = frame_q.pop_front();
                        check("frame_bits", got, expf);
                    end
                end
                dev_busy = 1'b0;
            end
        end
    end

    task automatic issue(input logic [7:0] b);
        int guard = 0;
        @(negedge clk);
        while (!tx_ready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_issue", tx_ready, 1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("ready_drops_after_accept", tx_ready, 0);
    endtask

    task automatic send(input logic [7:0] b, input mode_t m, input bit poke);
        int guard = 0;
        dev_mode = m;
        if (m == M_ACK || m == M_NACK || m == M_GLITCH) frame_q.push_back(ref_frame(b));
        exp_q.push_back(m == M_ACK || m == M_GLITCH);
        issue(b);
        if (poke) begin
            repeat (100) @(negedge clk);
            tx_data  = ~b;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
        end
        while (!(exp_q.size() == 0 && frame_q.size() == 0 && tx_ready && !dev_busy) && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        check("frame_completes_in_budget", guard < 20000, 1);
        if (guard >= 20000) begin
            exp_q.delete();
            frame_q.delete();
        end
        repeat (2) @(negedge clk);
        check("ready_after_frame", tx_ready, 1);
        check("oe_released_after_frame", {ps2_clk_oe, ps2_data_oe}, 0);
    endtask

    initial begin
        #(40 * 200000);
        $display("FAIL watchdog: simulation did not finish within cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        longint diff;
        int     guard;
        repeat (3) @(negedge clk);
        check("reset_tx_ready", tx_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_tx_done", tx_done, 0);
        check("reset_tx_error", tx_error, 0);
        check("reset_clk_oe", ps2_clk_oe, 0);
        check("reset_data_oe", ps2_data_oe, 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        send(8'hED, M_ACK, 1'b0);
        send(8'h00, M_ACK, 1'b0);
        send(8'h01, M_ACK, 1'b0);
        for (int i = 0; i < 4; i++) send(8'($urandom_range(0, 255)), M_ACK, 1'b1);

        send(8'hA5, M_NACK, 1'b0);

        send(8'h3C, M_SILENT, 1'b0);
        diff = err_cyc - rel_cyc;
        n_checks++;
        if (diff < TO - 2 || diff > TO + 20) begin
            n_fail++;
            $display("FAIL timeout_latency: actual %0d cycles required %0d..%0d", diff, TO - 2, TO + 20);
        end

        send(8'h96, M_GLITCH, 1'b0);

        // Reset while bit 4 (a zero, so data is driven low) is on the line.
        dev_mode  = M_ABORT;
        bit4_seen = 1'b0;
        issue(8'h00);
        guard = 0;
        while (!bit4_seen && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        check("abort_reached_bit4", bit4_seen, 1);
        repeat (20) @(negedge clk);
        check("bit4_data_driven", ps2_data_oe, 1);
        #3 reset_n = 1'b0;
        #1;
        check("async_reset_releases_lines", {ps2_clk_oe, ps2_data_oe}, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", tx_ready, 1);
        check("busy_after_reset", busy, 0);
        guard = 0;
        while (dev_busy && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        repeat (20) @(negedge clk);

        send(8'hFF, M_ACK, 1'b0);

        repeat (50) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        check("frame_queue_empty", frame_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
